// File: rtl/toy_bus_ddec_pipe_if.sv
// Request bus for the registered 1-to-N decoder: one valid/ready input,
// N valid/ready outputs that share one payload, and drop reporting.
interface toy_bus_ddec_pipe_if #(
    parameter int N_OUT  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4
);
    logic                  in_vld;
    logic                  in_rdy;
    logic [ADDR_W-1:0]     in_addr;
    logic [DATA_W/8-1:0]   in_strb;
    logic [DATA_W-1:0]     in_data;
    logic                  in_opcode;
    logic [ID_W-1:0]       in_src_id;
    logic [ID_W-1:0]       in_tgt_id;

    logic [N_OUT-1:0]      out_vld;
    logic [N_OUT-1:0]      out_rdy;
    logic [ADDR_W-1:0]     out_addr;
    logic [DATA_W/8-1:0]   out_strb;
    logic [DATA_W-1:0]     out_data;
    logic                  out_opcode;
    logic [ID_W-1:0]       out_src_id;
    logic [ID_W-1:0]       out_tgt_id;

    logic                  err_vld;
    logic [ID_W-1:0]       err_tgt_id;
    logic [7:0]            err_cnt;

    modport slave (
        input  in_vld, in_addr, in_strb, in_data, in_opcode, in_src_id, in_tgt_id,
        input  out_rdy,
        output in_rdy,
        output out_vld, out_addr, out_strb, out_data, out_opcode, out_src_id, out_tgt_id,
        output err_vld, err_tgt_id, err_cnt
    );

    modport master (
        output in_vld, in_addr, in_strb, in_data, in_opcode, in_src_id, in_tgt_id,
        output out_rdy,
        input  in_rdy,
        input  out_vld, out_addr, out_strb, out_data, out_opcode, out_src_id, out_tgt_id,
        input  err_vld, err_tgt_id, err_cnt
    );
endinterface

// File: rtl/toy_bus_ddec_pipe.sv
// Registered 1-to-N request decoder: one-entry pipeline register, table-driven
// routing, unmapped targets dropped with an error pulse and saturating count.
module toy_bus_ddec_pipe #(
    parameter int N_OUT  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4,
    parameter int PORT_W = $clog2(N_OUT),
    parameter logic [(2**ID_W)*PORT_W-1:0] ROUTE_MAP = '0,
    parameter logic [(2**ID_W)-1:0]        ROUTE_VLD = {(2**ID_W){1'b1}}
) (
    input  logic               clk,
    input  logic               rst_n,
    toy_bus_ddec_pipe_if.slave bus
);
    localparam int STRB_W = DATA_W / 8;

    logic                pipe_vld_q, pipe_vld_d;
    logic [PORT_W-1:0]   pipe_port_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [STRB_W-1:0]   strb_q;
    logic [DATA_W-1:0]   data_q;
    logic                opcode_q;
    logic [ID_W-1:0]     src_id_q;
    logic [ID_W-1:0]     tgt_id_q;

    logic                err_vld_q, err_vld_d;
    logic [ID_W-1:0]     err_tgt_id_q, err_tgt_id_d;
    logic [7:0]          err_cnt_q, err_cnt_d;

    logic [PORT_W-1:0]   dec_port;
    logic                dec_hit;
    logic [N_OUT-1:0]    out_vld_w;
    logic                drain;
    logic                accept;
    logic                load;
    logic                drop;

    // A table entry pointing past the last channel counts as unmapped.
    always_comb begin
        dec_port = ROUTE_MAP[bus.in_tgt_id*PORT_W +: PORT_W];
        dec_hit  = ROUTE_VLD[bus.in_tgt_id]
                   && ({{(32-PORT_W){1'b0}}, dec_port} < 32'(N_OUT));
    end

    for (genvar gi = 0; gi < N_OUT; gi++) begin : g_out_vld
        assign out_vld_w[gi] = pipe_vld_q && (pipe_port_q == PORT_W'(gi));
    end

    // Ready depends only on the held entry and out_rdy, never on in_vld.
    assign drain  = |(out_vld_w & bus.out_rdy);
    assign accept = bus.in_vld && bus.in_rdy;
    assign load   = accept && dec_hit;
    assign drop   = accept && !dec_hit;

    always_comb begin
        pipe_vld_d   = pipe_vld_q && !drain;
        err_vld_d    = drop;
        err_tgt_id_d = err_tgt_id_q;
        err_cnt_d    = err_cnt_q;
        if (load) begin
            pipe_vld_d = 1'b1;
        end
        if (drop) begin
            err_tgt_id_d = bus.in_tgt_id;
            if (err_cnt_q != 8'hFF) begin
                err_cnt_d = err_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_vld_q   <= 1'b0;
            err_vld_q    <= 1'b0;
            err_tgt_id_q <= '0;
            err_cnt_q    <= '0;
        end else begin
            pipe_vld_q   <= pipe_vld_d;
            err_vld_q    <= err_vld_d;
            err_tgt_id_q <= err_tgt_id_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    // Payload only moves on a routed accept; it is left in place after drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_port_q <= '0;
            addr_q      <= '0;
            strb_q      <= '0;
            data_q      <= '0;
            opcode_q    <= 1'b0;
            src_id_q    <= '0;
            tgt_id_q    <= '0;
        end else if (load) begin
            pipe_port_q <= dec_port;
            addr_q      <= bus.in_addr;
            strb_q      <= bus.in_strb;
            data_q      <= bus.in_data;
            opcode_q    <= bus.in_opcode;
            src_id_q    <= bus.in_src_id;
            tgt_id_q    <= bus.in_tgt_id;
        end
    end

    assign bus.in_rdy     = !pipe_vld_q || drain;
    assign bus.out_vld    = out_vld_w;
    assign bus.out_addr   = addr_q;
    assign bus.out_strb   = strb_q;
    assign bus.out_data   = data_q;
    assign bus.out_opcode = opcode_q;
    assign bus.out_src_id = src_id_q;
    assign bus.out_tgt_id = tgt_id_q;
    assign bus.err_vld    = err_vld_q;
    assign bus.err_tgt_id = err_tgt_id_q;
    assign bus.err_cnt    = err_cnt_q;
endmodule

// File: tb/tb_toy_bus_ddec_pipe.sv
// Bench for toy_bus_ddec_pipe: directed scenarios plus a randomized run
// checked against a transaction-level model of the decoder.
module tb_toy_bus_ddec_pipe;
    localparam int N_OUT  = 4;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int ID_W   = 4;
    // tgt 2->0, 3->1, 4->1, 5->2, 7->3
    localparam logic [31:0] MAP = 32'h0000_C940;
    localparam logic [15:0] VLD = 16'h00BC;

    logic clk;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    toy_bus_ddec_pipe_if #(.N_OUT(N_OUT), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) bus ();

    toy_bus_ddec_pipe #(
        .N_OUT(N_OUT), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W),
        .ROUTE_MAP(MAP), .ROUTE_VLD(VLD)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Routing rules written straight from the test setup table.
    function automatic int route(input logic [3:0] t);
        case (t)
            4'd2:       return 0;
            4'd3, 4'd4: return 1;
            4'd5:       return 2;
            4'd7:       return 3;
            default:    return -1;
        endcase
    endfunction

    // Transaction-level model: at most one held request plus drop bookkeeping.
    bit          m_vld;
    int          m_port;
    logic [31:0] m_addr, m_data;
    logic [3:0]  m_strb, m_src, m_tgt, m_err_tgt;
    logic        m_op, m_err_vld;
    int          m_err_cnt;

    task automatic model_reset();
        m_vld = 0; m_port = 0; m_addr = '0; m_data = '0; m_strb = '0;
        m_src = '0; m_tgt = '0; m_op = 1'b0; m_err_vld = 1'b0;
        m_err_tgt = '0; m_err_cnt = 0;
    endtask

    task automatic model_clock();
        bit taken, consumed;
        int r;
        consumed = m_vld && bus.out_rdy[m_port];
        taken    = bus.in_vld && (!m_vld || consumed);
        r        = route(bus.in_tgt_id);
        m_err_vld = taken && (r < 0);
        if (taken && r >= 0) begin
            m_vld = 1; m_port = r; m_addr = bus.in_addr; m_data = bus.in_data;
            m_strb = bus.in_strb; m_src = bus.in_src_id; m_tgt = bus.in_tgt_id;
            m_op = bus.in_opcode;
            $display("[TB] accept tgt=%0d port=%0d addr=%h", bus.in_tgt_id, r, bus.in_addr);
        end else begin
            if (consumed) m_vld = 0;
            if (taken) begin
                m_err_tgt = bus.in_tgt_id;
                m_err_cnt = (m_err_cnt < 255) ? m_err_cnt + 1 : 255;
                $display("[TB] drop tgt=%0d", bus.in_tgt_id);
            end
        end
    endtask

    task automatic drive(input bit v, input logic [3:0] t, input logic [31:0] a);
        bus.in_vld    = v;
        bus.in_tgt_id = t;
        bus.in_addr   = a;
        bus.in_data   = $urandom;
        bus.in_strb   = 4'($urandom);
        bus.in_opcode = 1'($urandom);
        bus.in_src_id = 4'($urandom);
    endtask

    task automatic test_reset();
        #2;
        n_tests++;
        if (bus.out_vld !== 4'b0 || bus.err_vld !== 1'b0 || bus.err_cnt !== 8'd0) begin
            n_fail++; $display("FAIL reset_outs: got vld=%b err=%b cnt=%0d expected 0/0/0", bus.out_vld, bus.err_vld, bus.err_cnt);
        end
        n_tests++;
        if (bus.in_rdy !== 1'b1) begin
            n_fail++; $display("FAIL reset_rdy: got %b expected 1", bus.in_rdy);
        end
        n_tests++;
        if (bus.out_addr !== 32'd0 || bus.out_data !== 32'd0 || bus.err_tgt_id !== 4'd0) begin
            n_fail++; $display("FAIL reset_payload: got addr=%h data=%h etgt=%0d expected 0", bus.out_addr, bus.out_data, bus.err_tgt_id);
        end
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if (bus.out_vld !== 4'b0 || bus.in_rdy !== 1'b1) begin
            n_fail++; $display("FAIL reset_release: got vld=%b rdy=%b expected 0000/1", bus.out_vld, bus.in_rdy);
        end
        $display("[TB] reset checked");
    endtask

    task automatic test_single();
        drive(1, 4'd5, 32'h1000);
        #1;
        n_tests++;
        if (bus.in_rdy !== 1'b1) begin
            n_fail++; $display("FAIL single_rdy: got %b expected 1", bus.in_rdy);
        end
        @(posedge clk); #1;
        drive(0, 4'd0, 32'h0);
        n_tests++;
        if (bus.out_vld !== 4'b0100 || bus.out_addr !== 32'h1000 || bus.out_tgt_id !== 4'd5) begin
            n_fail++; $display("FAIL single_out: got vld=%b addr=%h tgt=%0d expected 0100/1000/5", bus.out_vld, bus.out_addr, bus.out_tgt_id);
        end
        @(posedge clk); #1;
        n_tests++;
        if (bus.out_vld !== 4'b0 || bus.in_rdy !== 1'b1) begin
            n_fail++; $display("FAIL single_done: got vld=%b rdy=%b expected 0000/1", bus.out_vld, bus.in_rdy);
        end
        $display("[TB] single tgt=5 addr=1000");
    endtask

    task automatic test_back_to_back();
        logic [3:0]  tg  [4] = '{4'd2, 4'd3, 4'd7, 4'd4};
        logic [3:0]  exv [4] = '{4'b0001, 4'b0010, 4'b1000, 4'b0010};
        logic [31:0] ad;
        for (int i = 0; i < 4; i++) begin
            ad = 32'h2000 + 32'(i * 16);
            drive(1, tg[i], ad);
            @(posedge clk); #1;
            n_tests++;
            if (bus.out_vld !== exv[i] || bus.out_addr !== ad) begin
                n_fail++; $display("FAIL b2b_%0d: got vld=%b addr=%h expected %b/%h", i, bus.out_vld, bus.out_addr, exv[i], ad);
            end
            $display("[TB] b2b tgt=%0d vld=%b", tg[i], bus.out_vld);
        end
        drive(0, 4'd0, 32'h0);
        @(posedge clk); #1;
        n_tests++;
        if (bus.out_vld !== 4'b0) begin
            n_fail++; $display("FAIL b2b_end: got %b expected 0000", bus.out_vld);
        end
    endtask

    task automatic test_stall();
        bus.out_rdy = 4'b1101;
        drive(1, 4'd3, 32'hA000);
        @(posedge clk); #1;
        n_tests++;
        if (bus.out_vld !== 4'b0010) begin
            n_fail++; $display("FAIL stall_first: got %b expected 0010", bus.out_vld);
        end
        drive(1, 4'd2, 32'hB000);
        for (int i = 0; i < 5; i++) begin
            #1;
            n_tests++;
            if (bus.in_rdy !== 1'b0) begin
                n_fail++; $display("FAIL stall_rdy_%0d: got %b expected 0", i, bus.in_rdy);
            end
            @(posedge clk); #1;
            n_tests++;
            if (bus.out_vld !== 4'b0010 || bus.out_addr !== 32'hA000 || bus.out_tgt_id !== 4'd3) begin
                n_fail++; $display("FAIL stall_hold_%0d: got vld=%b addr=%h expected 0010/a000", i, bus.out_vld, bus.out_addr);
            end
        end
        bus.out_rdy = 4'b1111;
        #1;
        n_tests++;
        if (bus.in_rdy !== 1'b1) begin
            n_fail++; $display("FAIL stall_release_rdy: got %b expected 1", bus.in_rdy);
        end
        @(posedge clk); #1;
        drive(0, 4'd0, 32'h0);
        n_tests++;
        if (bus.out_vld !== 4'b0001 || bus.out_addr !== 32'hB000) begin
            n_fail++; $display("FAIL stall_next: got vld=%b addr=%h expected 0001/b000", bus.out_vld, bus.out_addr);
        end
        @(posedge clk); #1;
        $display("[TB] stall tgt=3 then tgt=2 delivered");
    endtask

    task automatic test_unmapped();
        drive(1, 4'd6, 32'h6);
        @(posedge clk); #1;
        drive(1, 4'd0, 32'h0);
        n_tests++;
        if (bus.err_vld !== 1'b1 || bus.err_tgt_id !== 4'd6 || bus.err_cnt !== 8'd1 || bus.out_vld !== 4'b0) begin
            n_fail++; $display("FAIL unmapped_6: got err=%b tgt=%0d cnt=%0d vld=%b expected 1/6/1/0000", bus.err_vld, bus.err_tgt_id, bus.err_cnt, bus.out_vld);
        end
        @(posedge clk); #1;
        drive(0, 4'd0, 32'h0);
        n_tests++;
        if (bus.err_vld !== 1'b1 || bus.err_tgt_id !== 4'd0 || bus.err_cnt !== 8'd2 || bus.out_vld !== 4'b0) begin
            n_fail++; $display("FAIL unmapped_0: got err=%b tgt=%0d cnt=%0d vld=%b expected 1/0/2/0000", bus.err_vld, bus.err_tgt_id, bus.err_cnt, bus.out_vld);
        end
        @(posedge clk); #1;
        n_tests++;
        if (bus.err_vld !== 1'b0 || bus.err_cnt !== 8'd2) begin
            n_fail++; $display("FAIL unmapped_idle: got err=%b cnt=%0d expected 0/2", bus.err_vld, bus.err_cnt);
        end
        $display("[TB] unmapped tgt=6,0 dropped");
    endtask

    task automatic test_saturate();
        logic [3:0] t;
        for (int i = 0; i < 300; i++) begin
            do t = 4'($urandom); while (route(t) >= 0);
            drive(1, t, $urandom);
            @(posedge clk); #1;
            n_tests++;
            if (bus.err_vld !== 1'b1 || bus.err_tgt_id !== t || bus.out_vld !== 4'b0) begin
                n_fail++; $display("FAIL sat_drop_%0d: got err=%b tgt=%0d vld=%b expected 1/%0d/0000", i, bus.err_vld, bus.err_tgt_id, bus.out_vld, t);
            end
        end
        drive(1, 4'd2, 32'hC0DE);
        n_tests++;
        if (bus.err_cnt !== 8'd255) begin
            n_fail++; $display("FAIL sat_cnt: got %0d expected 255", bus.err_cnt);
        end
        @(posedge clk); #1;
        drive(0, 4'd0, 32'h0);
        n_tests++;
        if (bus.out_vld !== 4'b0001 || bus.out_addr !== 32'hC0DE || bus.err_cnt !== 8'd255 || bus.err_vld !== 1'b0) begin
            n_fail++; $display("FAIL sat_routed: got vld=%b addr=%h cnt=%0d err=%b expected 0001/c0de/255/0", bus.out_vld, bus.out_addr, bus.err_cnt, bus.err_vld);
        end
        @(posedge clk); #1;
        $display("[TB] 300 drops, count saturated, tgt=2 delivered");
    endtask

    task automatic test_reset_mid();
        bus.out_rdy = 4'b0111;
        drive(1, 4'd7, 32'h7777);
        @(posedge clk); #1;
        drive(0, 4'd0, 32'h0);
        n_tests++;
        if (bus.out_vld !== 4'b1000) begin
            n_fail++; $display("FAIL rstmid_stall: got %b expected 1000", bus.out_vld);
        end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (bus.out_vld !== 4'b0 || bus.in_rdy !== 1'b1 || bus.out_addr !== 32'd0 || bus.err_cnt !== 8'd0) begin
            n_fail++; $display("FAIL rstmid_async: got vld=%b rdy=%b addr=%h cnt=%0d expected 0000/1/0/0", bus.out_vld, bus.in_rdy, bus.out_addr, bus.err_cnt);
        end
        @(negedge clk) rst_n = 1'b1;
        bus.out_rdy = 4'b1111;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            n_tests++;
            if (bus.out_vld !== 4'b0 || bus.in_rdy !== 1'b1) begin
                n_fail++; $display("FAIL rstmid_after_%0d: got vld=%b rdy=%b expected 0000/1", i, bus.out_vld, bus.in_rdy);
            end
        end
        $display("[TB] reset during stall discarded request");
    endtask

    task automatic test_random();
        bit exp_rdy;
        logic [3:0] exp_vld;
        model_reset();
        for (int i = 0; i < 500; i++) begin
            drive(($urandom % 4) != 0, 4'($urandom), $urandom);
            for (int k = 0; k < N_OUT; k++) bus.out_rdy[k] = ($urandom % 4) != 0;
            #1;
            exp_rdy = !m_vld || bus.out_rdy[m_port];
            n_tests++;
            if (bus.in_rdy !== exp_rdy) begin
                n_fail++; $display("FAIL rand_rdy_%0d: got %b expected %b", i, bus.in_rdy, exp_rdy);
            end
            model_clock();
            @(posedge clk); #1;
            exp_vld = m_vld ? 4'(1 << m_port) : 4'b0;
            n_tests++;
            if (bus.out_vld !== exp_vld || bus.out_addr !== m_addr || bus.out_data !== m_data
                || bus.out_strb !== m_strb || bus.out_opcode !== m_op
                || bus.out_src_id !== m_src || bus.out_tgt_id !== m_tgt) begin
                n_fail++; $display("FAIL rand_out_%0d: got vld=%b addr=%h tgt=%0d expected %b/%h/%0d", i, bus.out_vld, bus.out_addr, bus.out_tgt_id, exp_vld, m_addr, m_tgt);
            end
            n_tests++;
            if (bus.err_vld !== m_err_vld || bus.err_tgt_id !== m_err_tgt || bus.err_cnt !== 8'(m_err_cnt)) begin
                n_fail++; $display("FAIL rand_err_%0d: got err=%b tgt=%0d cnt=%0d expected %b/%0d/%0d", i, bus.err_vld, bus.err_tgt_id, bus.err_cnt, m_err_vld, m_err_tgt, m_err_cnt);
            end
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        bus.out_rdy = 4'b1111;
        drive(0, 4'd0, 32'h0);
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_unmapped();
        test_saturate();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
